msg_scheduler: RTL

//  SHA-224/256 message-schedule stage directly downstream of the padder.
//  - Accepts one padded 512-bit block per AXI-Stream beat.
//  - Expands the block into W0..W63 and streams one 32-bit word per cycle to the compression core.
//  - Also marks block boundaries and the final block of the message.

---
 rtl/sha2_sched_pkg.sv | 33 +++
 rtl/sha256_sched_next.sv | 18 +
 rtl/msg_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sha2_sched_pkg.sv
// Shared definitions for the SHA-224/256 message-schedule stage: sizes,
// the schedule state encoding and the small word helpers (rotate, sigma, byte swap).
package sha2_sched_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int ROUNDS  = 64;
  localparam int NUM_WIN = BLOCK_W / WORD_W;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } sched_state_e;

  function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x, input int unsigned n);
    rotr32 = (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0_256(input logic [WORD_W-1:0] x);
    sigma0_256 = rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1_256(input logic [WORD_W-1:0] x);
    sigma1_256 = rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  // The padder places message byte k in lane k, so each word needs its bytes reversed
  // to become a big-endian SHA-256 word.
  function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] x);
    bswap32 = {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sha256_sched_next.sv
// Combinational generator of the next schedule word:
// W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], modulo 2^32.
module sha256_sched_next
  import sha2_sched_pkg::*;
(
  input  logic [WORD_W-1:0] w0_i,
  input  logic [WORD_W-1:0] w1_i,
  input  logic [WORD_W-1:0] w9_i,
  input  logic [WORD_W-1:0] w14_i,
  output logic [WORD_W-1:0] w16_o
);

  // Four-input modular sum of the window taps and their sigma functions.
  always_comb begin
    w16_o = sigma1_256(w14_i) + w9_i + sigma0_256(w1_i) + w0_i;
  end

endmodule

// File: rtl/msg_scheduler.sv
// SHA-224/256 message-schedule stage. Takes one padded 512-bit block per input beat
// and streams W0..W63 out one word per cycle. A 16-word sliding window holds
// W[t]..W[t+15]; every accepted output word shifts it and appends W[t+16].
// A new block can be taken in the same cycle that W63 is accepted, so blocks
// stream with no bubble. That creates a combinational m_axis_tready -> s_axis_tready path.
// Optional feature macro: SCHED_ROUND_IDX_EN adds the m_axis_round output (current t).
module msg_scheduler
  import sha2_sched_pkg::*;
#(
  parameter int P_S_AXIS_DATA_WIDTH = 512,
  parameter int P_M_AXIS_DATA_WIDTH = 32,
  parameter int NUM_ROUNDS          = 64
) (
  input  logic                           axi_aclk,
  input  logic                           axi_reset,
  input  logic [P_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [P_M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [1:0]                     m_axis_tuser,
  output logic                           m_axis_tlast
`ifdef SCHED_ROUND_IDX_EN
  ,
  output logic [5:0]                     m_axis_round
`endif
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  if (P_S_AXIS_DATA_WIDTH != BLOCK_W) begin : g_bad_s_width
    $error("msg_scheduler: P_S_AXIS_DATA_WIDTH must be 512");
  end
  if (P_M_AXIS_DATA_WIDTH != WORD_W) begin : g_bad_m_width
    $error("msg_scheduler: P_M_AXIS_DATA_WIDTH must be 32");
  end
  if (NUM_ROUNDS != ROUNDS) begin : g_bad_rounds
    $error("msg_scheduler: NUM_ROUNDS must be 64");
  end

  sched_state_e      state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] win_q [NUM_WIN];
  logic [WORD_W-1:0] win_d [NUM_WIN];
  logic [WORD_W-1:0] w_next;
  logic              t_is_last;
  logic              in_hs;
  logic              out_hs;

  sha256_sched_next u_next (
    .w0_i  (win_q[0]),
    .w1_i  (win_q[1]),
    .w9_i  (win_q[9]),
    .w14_i (win_q[14]),
    .w16_o (w_next)
  );

  // Handshake decode; upstream is held off only through tready, never by ignoring it.
  always_comb begin
    t_is_last     = (t_q == T_LAST);
    m_axis_tvalid = (state_q == EXPAND);
    s_axis_tready = !axi_reset &&
                    ((state_q == IDLE) ||
                     ((state_q == EXPAND) && t_is_last && m_axis_tready));
    in_hs         = s_axis_tvalid && s_axis_tready;
    out_hs        = m_axis_tvalid && m_axis_tready;
  end

  // Output word and sideband flags, all decoded straight from state flops.
  always_comb begin
    m_axis_tdata = win_q[0];
    m_axis_tuser = m_axis_tvalid ? {t_is_last, (t_q == 6'd0)} : 2'b00;
    m_axis_tlast = m_axis_tvalid && t_is_last && last_q;
  end

`ifdef SCHED_ROUND_IDX_EN
  // Round index exposed alongside the word it belongs to.
  always_comb begin
    m_axis_round = t_q;
  end
`endif

  // Next-state logic: a block load wins over the shift, which makes the back-to-back reload work.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    last_d  = last_q;
    win_d   = win_q;
    if (in_hs) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        win_d[i] = bswap32(s_axis_tdata[WORD_W*i +: WORD_W]);
      end
      last_d  = s_axis_tlast;
      t_d     = 6'd0;
      state_d = EXPAND;
    end else if (out_hs) begin
      for (int i = 0; i < NUM_WIN - 1; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[NUM_WIN-1] = w_next;
      t_d              = t_q + 6'd1;
      if (t_is_last) begin
        state_d = IDLE;
      end
    end
  end

  // Schedule state register; reset clears the window so outputs read zero immediately.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      last_q  <= 1'b0;
      for (int i = 0; i < NUM_WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      last_q  <= last_d;
      for (int i = 0; i < NUM_WIN; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

endmodule
